keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 active-low matrix keypad and debounces it. Each press produces exactly one
//   4-bit key code with a one-cycle en_key pulse. Also raises count_en when the gap
//   between digits runs too long. Drives the key/en_key/count_en inputs of the password
//   state machine; sits between the GPIO keypad header and the lock FSM.
// PARAMETERS
//   SCAN_DIV      16        clk cycles each column is driven low (dwell); >=4
//   DEBOUNCE_CYC  500000    consecutive stable cycles required for press and for release
//   TIMEOUT_CYC   250000000 idle cycles after last en_key before count_en fires (5 s @ 50 MHz)
// PORTS
//   clk       in   1  system clock
//   rst       in   1  synchronous, active-high reset
//   row_n     in   4  keypad rows, active-low, externally pulled up, asynchronous
//   col_n     out  4  keypad column drive, active-low, one-hot-low
//   key       out  4  code of last accepted key, held until next accept
//   en_key    out  1  one-cycle pulse: key is valid this cycle
//   count_en  out  1  one-cycle pulse: inter-digit timeout, tells consumer to restart entry
//   key_held  out  1  high while a press is accepted and not yet released
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//   - Next cycle: col_n=4'b1110, key=0, en_key=0, count_en=0, key_held=0.
//   - State SCAN, col_idx=0. All counters, synchronisers and the pending flag cleared.
//   - Applies in any state; a pulse in progress is never emitted after reset.
//   Input path:
//   - row_n passes through a 2-flop synchroniser (rows_s); all logic uses rows_s only.
//   - Key code = {row_idx[1:0], col_idx[1:0]} (row*4+col); e.g. row1,col1 -> 4'h5.
//   FSM, 4 states:
//   - SCAN: col_n=~(1<<col_idx). Dwell counter runs 0..SCAN_DIV-1.
//     - On the last dwell cycle, rows_s is sampled.
//     - Exactly one row low: capture row_idx/col_idx, go DEBOUNCE, column frozen.
//     - Zero or >=2 rows low (ghost/multi-key): col_idx advances, 3 wraps to 0.
//   - DEBOUNCE: column held. Stable counter increments each cycle rows_s equals the captured pattern.
//     - Any mismatch: go SCAN at next column.
//     - Counter reaches DEBOUNCE_CYC: go EMIT.
//   - EMIT (one cycle): key<=code, en_key=1, key_held<=1, go WAIT_RELEASE.
//     - en_key is a registered output, high exactly DEBOUNCE_CYC+1 cycles after DEBOUNCE entry.
//   - WAIT_RELEASE: column held, no further en_key however long the key is held.
//     - Requires rows_s==4'hF for DEBOUNCE_CYC consecutive cycles; any low row restarts the count.
//     - On completion: key_held<=0, go SCAN, col_idx=0.
//   Timeout:
//   - pending flag is set by en_key and cleared by count_en or reset.
//   - While pending, the idle counter increments each cycle and is cleared by en_key.
//   - Idle counter reaching TIMEOUT_CYC: count_en=1 for one cycle, pending<=0, counter<=0.
//   - No count_en unless at least one key was accepted since the last timeout or reset.
//   - en_key and a timeout in the same cycle: en_key wins, counter cleared, no count_en.
//   - count_en fires even while key_held=1.
//   Widths: counters sized $clog2(param+1). No counter wraps; each saturates/clears as above.
// TESTING (bench params SCAN_DIV=4, DEBOUNCE_CYC=8, TIMEOUT_CYC=200)
//   1. Hold row1 low while col1 is driven, for 60 cycles, then release
//      -> exactly one en_key with key=4'h5; key_held high until 8 cycles after release;
//      scanning resumes with col_n=4'b1110.
//   2. Bounce row2 (toggle every 3 cycles for 30 cycles), then hold on col0
//      -> one en_key only, key=4'h8, no pulse during bounce.
//   3. Rows 0 and 3 both low on col2 for 100 cycles -> no en_key; col_n keeps cycling.
//   4. Press sequence 2,5,8,5 with releases -> four en_key pulses with key=2,5,8,5 in order;
//      lock FSM o_unlock=1 afterward.
//   5. Timing of count_en:
//      - One press, then idle -> single count_en exactly 200 cycles after en_key.
//      - 1000 cycles idle from reset -> count_en never asserts.
//   6. rst pulse mid-DEBOUNCE, and separately mid-WAIT_RELEASE
//      -> no en_key; next cycle col_n=4'b1110, key=0, key_held=0, count_en=0.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce and an
// inter-digit timeout pulse for the downstream password FSM.
module keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int TIMEOUT_CYC  = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key,
  output logic       en_key,
  output logic       count_en,
  output logic       key_held
);
  localparam int DW  = $clog2(SCAN_DIV + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     rows_p0, rows_s;
  logic [DW-1:0]  dwell_cnt, dwell_nxt;
  logic [DBW-1:0] stable_cnt, stable_nxt;
  logic [1:0]     col_idx, col_nxt;
  logic [1:0]     row_idx, row_nxt;
  logic [3:0]     pattern, pattern_nxt;
  logic [TOW-1:0] idle_cnt;
  logic           pending;

  function automatic logic single_low(input logic [3:0] r);
    return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    case (r)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign col_n = ~(4'b0001 << col_idx);

  always_comb begin
    state_nxt   = state;
    dwell_nxt   = dwell_cnt;
    stable_nxt  = stable_cnt;
    col_nxt     = col_idx;
    row_nxt     = row_idx;
    pattern_nxt = pattern;
    case (state)
      SCAN: begin
        // rows_s lags the column drive by two cycles, so only the last dwell cycle is trusted
        if (dwell_cnt == DW'(SCAN_DIV - 1)) begin
          dwell_nxt = '0;
          if (single_low(rows_s)) begin
            state_nxt   = DEBOUNCE;
            row_nxt     = low_index(rows_s);
            pattern_nxt = rows_s;
            stable_nxt  = '0;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rows_s == pattern) begin
          if (stable_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
            state_nxt  = EMIT;
            stable_nxt = '0;
          end else begin
            stable_nxt = stable_cnt + 1'b1;
          end
        end else begin
          state_nxt  = SCAN;
          stable_nxt = '0;
          col_nxt    = col_idx + 2'd1;
        end
      end
      EMIT: begin
        state_nxt  = WAIT_RELEASE;
        stable_nxt = '0;
      end
      WAIT_RELEASE: begin
        if (rows_s == 4'hF) begin
          if (stable_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
            state_nxt  = SCAN;
            stable_nxt = '0;
            col_nxt    = 2'd0;
          end else begin
            stable_nxt = stable_cnt + 1'b1;
          end
        end else begin
          stable_nxt = '0;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN;
      rows_p0    <= 4'hF;
      rows_s     <= 4'hF;
      dwell_cnt  <= '0;
      stable_cnt <= '0;
      col_idx    <= 2'd0;
      row_idx    <= 2'd0;
      pattern    <= 4'hF;
      key        <= 4'h0;
      en_key     <= 1'b0;
      key_held   <= 1'b0;
      count_en   <= 1'b0;
      pending    <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      rows_p0    <= row_n;
      rows_s     <= rows_p0;
      state      <= state_nxt;
      dwell_cnt  <= dwell_nxt;
      stable_cnt <= stable_nxt;
      col_idx    <= col_nxt;
      row_idx    <= row_nxt;
      pattern    <= pattern_nxt;
      en_key     <= (state == EMIT);
      count_en   <= 1'b0;
      if (state == EMIT) begin
        key      <= {row_idx, col_idx};
        key_held <= 1'b1;
      end else if (state == WAIT_RELEASE && state_nxt == SCAN) begin
        key_held <= 1'b0;
      end
      // Arming on EMIT makes the idle count line up with the en_key cycle; a fresh key beats a timeout
      if (state == EMIT) begin
        pending  <= 1'b1;
        idle_cnt <= '0;
      end else if (pending) begin
        if (idle_cnt == TOW'(TIMEOUT_CYC - 1)) begin
          count_en <= 1'b1;
          pending  <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a mask-driven keypad model closes row/column
// contacts and each step is checked with an immediate assertion.
module tb_keypad_scanner;
  logic       clk;
  logic       rst;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key;
  logic       en_key;
  logic       count_en;
  logic       key_held;

  logic [15:0] mask;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int ce_cnt = 0;
  int en_cyc = 0;
  int ce_cyc = 0;
  logic [3:0] key_log [16];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYC(8), .TIMEOUT_CYC(200)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key(key), .en_key(en_key), .count_en(count_en), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en_key) begin
      key_log[en_cnt % 16] = key;
      en_cnt = en_cnt + 1;
      en_cyc = cyc;
    end
    if (count_en) begin
      ce_cnt = ce_cnt + 1;
      ce_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_col_n"}, int'(col_n), 4'b1110);
    check({tag, "_key"}, int'(key), 0);
    check({tag, "_en_key"}, int'(en_key), 0);
    check({tag, "_count_en"}, int'(count_en), 0);
    check({tag, "_key_held"}, int'(key_held), 0);
  endtask

  int en_base, ce_base, changes;
  logic [3:0] prev_col;
  logic [3:0] seq [4];

  initial begin
    rst = 1'b1;
    mask = '0;
    seq[0] = 4'h2; seq[1] = 4'h5; seq[2] = 4'h8; seq[3] = 4'h5;
    wait_cyc(2);
    do_reset();
    check_reset_state("reset");

    // Test 1: row1/col1 held for 60 cycles
    en_base = en_cnt; ce_base = ce_cnt;
    mask = 16'h0020;
    wait_cyc(60);
    check("t1_en_count", en_cnt - en_base, 1);
    check("t1_key", int'(key), 5);
    check("t1_held", int'(key_held), 1);
    mask = '0;
    wait_cyc(9);
    check("t1_held_before_release_done", int'(key_held), 1);
    wait_cyc(1);
    check("t1_held_dropped", int'(key_held), 0);
    check("t1_col_restart", int'(col_n), 4'b1110);
    check("t1_no_extra_en", en_cnt - en_base, 1);

    // Test 2: bounce on key 8 then a clean hold
    do_reset();
    en_base = en_cnt;
    for (int i = 0; i < 10; i++) begin
      mask = mask ^ 16'h0100;
      wait_cyc(3);
    end
    check("t2_no_en_in_bounce", en_cnt - en_base, 0);
    check("t2_key_unchanged", int'(key), 0);
    mask = 16'h0100;
    wait_cyc(40);
    check("t2_en_count", en_cnt - en_base, 1);
    check("t2_key", int'(key), 8);
    mask = '0;
    wait_cyc(20);

    // Test 3: ghost pattern, rows 0 and 3 on col2
    do_reset();
    en_base = en_cnt;
    mask = 16'h4004;
    changes = 0;
    prev_col = col_n;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (col_n != prev_col) changes++;
      prev_col = col_n;
    end
    check("t3_no_en", en_cnt - en_base, 0);
    check("t3_col_changes", changes, 25);
    check("t3_not_held", int'(key_held), 0);
    mask = '0;

    // Test 4: sequence 2,5,8,5
    do_reset();
    en_base = en_cnt; ce_base = ce_cnt;
    for (int i = 0; i < 4; i++) begin
      mask = 16'h0001 << seq[i];
      wait_cyc(40);
      mask = '0;
      wait_cyc(20);
    end
    check("t4_en_count", en_cnt - en_base, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_key%0d", i), int'(key_log[(en_base + i) % 16]), int'(seq[i]));
    check("t4_no_timeout", ce_cnt - ce_base, 0);

    // Test 5a: single press then idle
    do_reset();
    en_base = en_cnt; ce_base = ce_cnt;
    mask = 16'h0020;
    wait_cyc(40);
    mask = '0;
    wait_cyc(260);
    check("t5_en_count", en_cnt - en_base, 1);
    check("t5_ce_count", ce_cnt - ce_base, 1);
    check("t5_ce_delay", ce_cyc - en_cyc, 200);

    // Test 5b: idle from reset
    do_reset();
    ce_base = ce_cnt;
    wait_cyc(1000);
    check("t5_idle_no_ce", ce_cnt - ce_base, 0);

    // Test 6a: reset during debounce of key 0
    do_reset();
    en_base = en_cnt;
    mask = 16'h0001;
    wait_cyc(6);
    do_reset();
    mask = '0;
    check_reset_state("t6a");
    wait_cyc(20);
    check("t6a_no_en", en_cnt - en_base, 0);

    // Test 6b: reset while waiting for release of key 5
    do_reset();
    en_base = en_cnt; ce_base = ce_cnt;
    mask = 16'h0020;
    wait_cyc(30);
    check("t6b_en_before", en_cnt - en_base, 1);
    check("t6b_key_before", int'(key), 5);
    check("t6b_held_before", int'(key_held), 1);
    do_reset();
    mask = '0;
    check_reset_state("t6b");
    wait_cyc(250);
    check("t6b_no_en_after", en_cnt - en_base, 1);
    check("t6b_no_ce_after", ce_cnt - ce_base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
